// File: rtl/mem_io_bridge.sv
// Data-side bridge for the MIPS core: external RAM passthrough plus an MMIO page with GPIO,
// synchronized switches, a free-running timer and a FIFO-buffered UART transmitter.
module mem_io_bridge #(
   parameter int unsigned BAUD_DIV   = 868,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   input  logic [31:0] ram_dout,
   input  logic [15:0] sw_in,
   output logic [15:0] gpio_out,
   output logic        uart_tx
);

   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned BaudW = $clog2(BAUD_DIV + 1);
   localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
   localparam logic [PtrW-1:0]  PtrLast  = PtrW'(FIFO_DEPTH - 1);
   localparam logic [2:0]       CntFull  = 3'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic             ram_hit, mmio_hit;
   logic [5:0]       reg_off;
   logic             wr_gpio, wr_timer, wr_uart, wr_stat;
   logic             push_ok, pop, drop, busy, full;
   logic [15:0]      gpio_q, gpio_d;
   logic [15:0]      sw_meta_q, sw_sync_q;
   logic [31:0]      timer_q, timer_d;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;
   logic             ovf_q, ovf_d;
   state_e           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic             tx_q, tx_d;
   logic             unused_ok;

   // Reads have no side effects, so the read strobe and byte offset are not needed.
   assign unused_ok = ^{mem_ren, mem_addr[1:0]};

   assign ram_hit  = (mem_addr[31:16] == 16'h0000);
   assign mmio_hit = (mem_addr[31:8] == 24'hFFFF00);
   assign reg_off  = mem_addr[7:2];
   assign wr_gpio  = mem_wen & mmio_hit & (reg_off == 6'd0);
   assign wr_timer = mem_wen & mmio_hit & (reg_off == 6'd2);
   assign wr_uart  = mem_wen & mmio_hit & (reg_off == 6'd3);
   assign wr_stat  = mem_wen & mmio_hit & (reg_off == 6'd4);

   assign ram_wen  = mem_wen & ram_hit;
   assign ram_addr = mem_addr;
   assign ram_din  = mem_dout;
   assign gpio_out = gpio_q;
   assign uart_tx  = tx_q;

   assign busy = (state_q != StIdle) | (count_q != 3'd0);
   assign full = (count_q == CntFull);

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_din = '0;
      if (ram_hit) begin
         mem_din = ram_dout;
      end else if (mmio_hit) begin
         case (reg_off)
            6'd0:    mem_din = {16'h0000, gpio_q};
            6'd1:    mem_din = {16'h0000, sw_sync_q};
            6'd2:    mem_din = timer_q;
            6'd4:    mem_din = {26'd0, count_q, ovf_q, full, busy};
            default: mem_din = '0;
         endcase
      end
   end

   // UART transmit FSM; a frame ending with data queued pops straight into the next START.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = (baud_q == '0) ? BaudLast : baud_q - 1'b1;
      pop       = 1'b0;
      unique case (state_q)
         StIdle: begin
            baud_d = BaudLast;
            if (count_q != 3'd0) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr_q];
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_q == '0) begin
               state_d   = StData;
               bit_cnt_d = 3'd0;
            end
         end
         StData: begin
            if (baud_q == '0) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         StStop: begin
            if (baud_q == '0) begin
               if (count_q != 3'd0) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr_q];
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_comb begin
      gpio_d   = wr_gpio ? mem_dout[15:0] : gpio_q;
      timer_d  = wr_timer ? mem_dout : timer_q + 32'd1;
      push_ok  = wr_uart & ((count_q != CntFull) | pop);
      drop     = wr_uart & ~push_ok;
      wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
      ovf_d = wr_stat ? 1'b0 : (drop | ovf_q);
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= mem_dout[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_q    <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
         timer_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         baud_q    <= BaudLast;
         tx_q      <= 1'b1;
      end else begin
         gpio_q    <= gpio_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
         timer_q   <= timer_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: vector table, directed UART/timer/reset sequences and
// randomized accesses against a frame-level behavioural model.
module tb_mem_io_bridge;

   localparam int unsigned Baud  = 4;
   localparam int unsigned Depth = 4;
   localparam logic [31:0] AGpio = 32'hFFFF0000;
   localparam logic [31:0] ASw   = 32'hFFFF0004;
   localparam logic [31:0] ATmr  = 32'hFFFF0008;
   localparam logic [31:0] AUart = 32'hFFFF000C;
   localparam logic [31:0] AStat = 32'hFFFF0010;

   logic        clk = 1'b0;
   logic        rst, mem_ren, mem_wen, ram_wen, uart_tx;
   logic [31:0] mem_addr, mem_dout, mem_din, ram_addr, ram_din, ram_dout;
   logic [15:0] sw_in, gpio_out;

   mem_io_bridge #(.BAUD_DIV(Baud), .FIFO_DEPTH(Depth)) dut (
      .clk(clk), .rst(rst), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout), .sw_in(sw_in), .gpio_out(gpio_out),
      .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Behavioural model: register values, a byte queue and a frame countdown for the line.
   logic [15:0] m_gpio, m_sw1, m_sw2;
   logic [31:0] m_timer;
   logic [7:0]  m_q [$];
   logic        m_ovf;
   int          m_left;
   logic [7:0]  m_cur;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [31:0] rdout;
      logic [31:0] exp_din;
      logic        exp_ram_wen;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic m_tx();
      int idx;
      if (m_left == 0) return 1'b1;
      idx = (10 * Baud - m_left) / Baud;
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return m_cur[idx-1];
   endfunction

   function automatic logic [31:0] m_stat();
      logic busy, full;
      busy = (m_left != 0) || (m_q.size() != 0);
      full = (m_q.size() == Depth);
      return {26'd0, 3'(m_q.size()), m_ovf, full, busy};
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] rd);
      if (a[31:16] == 16'h0000) return rd;
      if (a[31:8] != 24'hFFFF00) return 32'h0;
      case (a[7:0] & 8'hFC)
         8'h00:   return {16'h0, m_gpio};
         8'h04:   return {16'h0, m_sw2};
         8'h08:   return m_timer;
         8'h10:   return m_stat();
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic       wr;
      logic [7:0] off;
      logic       popped;
      if (rst) begin
         m_gpio = '0; m_sw1 = '0; m_sw2 = '0; m_timer = '0; m_ovf = 1'b0; m_left = 0;
         m_q.delete();
         return;
      end
      wr  = mem_wen && (mem_addr[31:8] == 24'hFFFF00);
      off = mem_addr[7:0] & 8'hFC;
      m_timer = (wr && off == 8'h08) ? mem_dout : m_timer + 32'd1;
      if (wr && off == 8'h00) m_gpio = mem_dout[15:0];
      m_sw2 = m_sw1;
      m_sw1 = sw_in;
      popped = 1'b0;
      if (m_left <= 1) begin
         if (m_q.size() > 0) begin
            m_cur  = m_q.pop_front();
            m_left = 10 * Baud;
            popped = 1'b1;
         end else begin
            m_left = 0;
         end
      end else begin
         m_left--;
      end
      if (wr && off == 8'h0C) begin
         if (m_q.size() < Depth || popped) m_q.push_back(mem_dout[7:0]);
         else m_ovf = 1'b1;
      end
      if (wr && off == 8'h10) m_ovf = 1'b0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("uart_tx", 32'(uart_tx), 32'(m_tx()));
      chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = a;
      #1;
      chk(name, mem_din, exp);
      tick();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = a; mem_dout = d;
      tick();
      mem_wen = 1'b0;
   endtask

   initial begin
      logic [9:0] frame;
      int         k, sel;
      rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
      ram_dout = '0; sw_in = '0;
      m_q.delete();
      tick();
      tick();
      rst = 1'b0;
      rd_chk("timer_reset", ATmr, 32'h0);
      rd_chk("stat_reset", AStat, 32'h0);
      rd_chk("gpio_reset", AGpio, 32'h0);

      vecs[0]  = '{1'b0, 1'b1, 32'h00000040, 32'h12345678, 32'h0BAD0BAD, 32'h0BAD0BAD, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 32'h00000040, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'hDEADBEEF, 32'h1234, 32'h0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h80000000, 32'h0, 32'h1234, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, AGpio, 32'hABCD1234, 32'h5555, 32'h0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, AGpio, 32'h0, 32'h5555, 32'h00001234, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFFF0014, 32'h0, 32'h5555, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, AUart, 32'h0, 32'h5555, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'hFFFF0100, 32'h0, 32'h5555, 32'h0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000FFFC, 32'h0, 32'h5, 32'h5, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'h00010000, 32'h0, 32'h7, 32'h0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'hFFFF0003, 32'h0000BEEF, 32'h0, 32'h00001234, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 32'hFFFF0002, 32'h0, 32'h0, 32'h0000BEEF, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 32'h00000080, 32'h77777777, 32'hAAAA, 32'hAAAA, 1'b1};
      for (int i = 0; i < 14; i++) begin
         mem_ren = vecs[i].ren; mem_wen = vecs[i].wen; mem_addr = vecs[i].addr;
         mem_dout = vecs[i].dout; ram_dout = vecs[i].rdout;
         #1;
         chk($sformatf("vec%0d_din", i), mem_din, vecs[i].exp_din);
         chk($sformatf("vec%0d_ram_wen", i), 32'(ram_wen), 32'(vecs[i].exp_ram_wen));
         chk($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].addr);
         chk($sformatf("vec%0d_ram_din", i), ram_din, vecs[i].dout);
         tick();
      end
      mem_wen = 1'b0;
      chk("gpio_after_table", 32'(gpio_out), 32'h0000BEEF);

      // Timer load then wrap.
      wr(ATmr, 32'hFFFFFFFE);
      rd_chk("timer_fe", ATmr, 32'hFFFFFFFE);
      rd_chk("timer_ff", ATmr, 32'hFFFFFFFF);
      rd_chk("timer_wrap", ATmr, 32'h00000000);

      // Switch synchronizer latency.
      sw_in = 16'h00F0;
      rd_chk("sw_lat0", ASw, 32'h0);
      rd_chk("sw_lat1", ASw, 32'h0);
      rd_chk("sw_lat2", ASw, 32'h000000F0);
      rd_chk("sw_lat3", ASw, 32'h000000F0);

      // Single frame of 0x55.
      frame = {1'b1, 8'h55, 1'b0};
      wr(AUart, 32'h55);
      mem_ren = 1'b1; mem_addr = AStat;
      for (int c = 0; c < 40; c++) begin
         tick();
         chk($sformatf("frame_bit%0d", c), 32'(uart_tx), 32'(frame[c/4]));
         chk($sformatf("frame_busy%0d", c), 32'(mem_din[0]), 32'h1);
      end
      tick();
      chk("frame_idle_tx", 32'(uart_tx), 32'h1);
      chk("frame_idle_busy", 32'(mem_din[0]), 32'h0);

      // Overflow: six back-to-back pushes.
      wr(AUart, 32'hA0);
      k = cyc;
      for (int i = 1; i < 6; i++) wr(AUart, 32'hA0 + 32'(i));
      rd_chk("stat_overflow", AStat, 32'h27);
      wr(AStat, 32'hFFFFFFFF);
      rd_chk("stat_cleared", AStat, 32'h23);
      mem_ren = 1'b1; mem_addr = AStat;
      #1;
      for (int i = 0; i < 400; i++) begin
         if (mem_din[0] == 1'b0) break;
         tick();
      end
      chk("five_frames_len", 32'(cyc - k), 32'd201);

      // Reset during the data bits of a 0x00 frame.
      wr(AGpio, 32'h00FF);
      wr(ATmr, 32'h1234);
      wr(AUart, 32'h00);
      for (int i = 0; i < 12; i++) tick();
      chk("tx_before_rst", 32'(uart_tx), 32'h0);
      rst = 1'b1;
      tick();
      chk("tx_after_rst", 32'(uart_tx), 32'h1);
      chk("gpio_after_rst", 32'(gpio_out), 32'h0);
      rst = 1'b0;
      rd_chk("timer_after_rst", ATmr, 32'h0);
      rd_chk("stat_after_rst", AStat, 32'h0);

      // Randomized accesses against the model.
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         sel = $urandom_range(0, 9);
         if (sel < 3) mem_addr = {16'h0000, 16'($urandom)};
         else if (sel < 9) mem_addr = {24'hFFFF00, 8'($urandom_range(0, 31))};
         else mem_addr = $urandom;
         mem_ren  = 1'($urandom);
         mem_wen  = 1'($urandom);
         mem_dout = $urandom;
         ram_dout = $urandom;
         if ($urandom_range(0, 7) == 0) sw_in = 16'($urandom);
         #1;
         if (mem_ren) chk("rnd_din", mem_din, m_read(mem_addr, ram_dout));
         chk("rnd_ram_wen", 32'(ram_wen), 32'(mem_wen && mem_addr[31:16] == 16'h0));
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
